muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It owns the architectural HI/LO registers and runs a fixed-latency multiply or an iterative radix-2 restoring divide. It raises `stall` to freeze IF/ID/EX whenever EX needs HI/LO or the unit while an operation is in flight. It sits beside the ALU and the forwarding logic; `stall` feeds the hazard/pipeline-enable logic.

## Interface
- `MULT_CYCLES`, default 4: multiply latency in cycles, legal range 1..16.
- `XLEN`, default 32: operand width. Only 32 is verified.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_mult`  in  1  mult/multu is in EX this cycle.
- `start_div`  in  1  div/divu is in EX this cycle. Never asserted together with `start_mult`.
- `is_signed`  in  1  signed variant; sampled with `start_*`.
- `op_a`, `op_b`  in  32 each  forwarded rs/rt values (`sourceA_ex`/`sourceB_ex`).
- `mfhi_ex`, `mflo_ex`  in  1 each  mfhi/mflo is in EX.
- `mthi_wb`, `mtlo_wb`  in  1 each  mthi/mtlo is committing in WB.
- `wb_data`  in  32  WB result for mthi/mtlo.
- `flush`  in  1  exception/branch squash of the in-flight op.
- `stall`  out  1  combinational pipeline freeze request.
- `busy`  out  1  FSM is not IDLE.
- `done`  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- `div_by_zero`  out  1  sticky until the next start; set when the divisor was 0.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- FSM states and transitions:
  - IDLE:
    - `start_mult` → MUL_RUN, counter = MULT_CYCLES−1.
    - `start_div` → DIV_RUN, counter = 31.
  - MUL_RUN / DIV_RUN: decrement each cycle. On the edge with counter==0, write HI/LO, go to IDLE, set `done`.
- Operands are captured on the start edge. Later changes to `op_a`/`op_b` are ignored.
- Multiply:
  - Full 64-bit product; signed when `is_signed`.
  - HI = product[63:32], LO = product[31:0].
  - The product is held in an internal register and written to HI/LO at completion.
- Divide:
  - Operands are converted to magnitudes, then 32 restoring steps run, one quotient bit per cycle.
  - Sign fixup is applied combinationally on the write edge: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - Signed 0x80000000 / −1 gives LO = 0x80000000, HI = 0.
- Divide by zero:
  - Still takes 32 cycles.
  - LO = 0xFFFF_FFFF, HI = `op_a` (signed or unsigned).
  - `div_by_zero` = 1.
- `stall` = `busy` & (`start_mult` | `start_div` | `mfhi_ex` | `mflo_ex`).
  - A start presented while busy is ignored and re-presented after release.
- mthi/mtlo:
  - Write the selected half from `wb_data` on the next edge, in any state.
  - On the same edge as a completion write, mt* wins for its half; the other half takes the result.
- `flush` while busy: next edge → IDLE, no HI/LO write, no `done`. `flush` in IDLE has no effect.
  - `flush` together with a start in IDLE: the start is ignored.
- Reset (also mid-operation): state IDLE, counter 0, HI = LO = 0, `done` = 0, `div_by_zero` = 0, `busy` = 0, `stall` = 0.

## Timing
- Start is sampled at edge E0.
- The write to HI/LO happens at edge E0+MULT_CYCLES (multiply) or E0+32 (divide).
- `done` is high during the cycle after the write edge.
- `busy` is high from E0 to the write edge inclusive of the cycles between, and low the cycle `done` is high.
- An mfhi in EX during the `done` cycle reads the new value with no stall.
- Back-to-back: a start in the `done` cycle is accepted immediately. Throughput is one op per latency; no idle bubble is required.
- `stall` has no registered delay; it depends on `busy` (registered) and EX decode inputs only.

## Structure
- `muldiv_pkg`:
  - `state_t` enum {IDLE, MUL_RUN, DIV_RUN}.
  - `DIV_ITERS` = 32.
  - Counter width `CNT_W` = 5.
  - Function `abs32`.
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: remainder, quotient, divisor. Outputs: next remainder and next quotient.
  - Instantiated once and iterated by the FSM.
- Multiplier: behavioural `*` into the product register. Latency is modelled by the counter.

## Test plan
- Unsigned multiply: multu 0xFFFF_FFFF × 2 → after 4 cycles HI = 0x1, LO = 0xFFFF_FFFE, one `done` pulse.
- Signed divide: div −7 / 2 → after 32 cycles LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. Also 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- Divide by zero: divu 5 / 0 → LO = 0xFFFF_FFFF, HI = 5, `div_by_zero` = 1.
- Hazard stall: mflo_ex asserted 2 cycles after a div starts → `stall` held until the write edge, deasserts in the `done` cycle with the new LO visible. A second start_mult while busy → stalled, then accepted in the `done` cycle.
- Flush and reset mid-op:
  - `flush` at cycle 10 of a divide → IDLE next cycle, HI/LO unchanged, no `done`.
  - `rst_n` = 0 mid-multiply → HI = LO = 0, `busy` = 0.
- Write collision: mthi_wb with wb_data 0x1234 on the multiply completion edge → HI = 0x1234, LO = product low half.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  // Magnitude of v; treated as unsigned when sgn is clear.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      abs32 = ~v + 32'd1;
    end else begin
      abs32 = v;
    end
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One combinational restoring-division iteration: the dividend is shifted out of
// the quotient register MSB-first while quotient bits are shifted in at the LSB.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted_s;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  always_comb begin
    shifted_s = {rem_i, quo_i[31]};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o = shifted_s[31:0] - divisor_i;
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted_s[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO; fixed-latency multiply and
// 32-cycle radix-2 restoring divide with pipeline stall generation.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_mult,
  input  logic            start_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            mfhi_ex,
  input  logic            mflo_ex,
  input  logic            mthi_wb,
  input  logic            mtlo_wb,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     rem_q, quo_q, dvsr_q, a_q;
  logic                qneg_q, rneg_q, dz_q;
  logic [XLEN-1:0]     hi_q, lo_q;
  logic                done_q, dbz_q;

  logic [XLEN-1:0]     rem_nx_s, quo_nx_s;
  logic [XLEN-1:0]     res_hi_s, res_lo_s;
  logic [2*XLEN-1:0]   ext_a_s, ext_b_s;
  logic                busy_s, fire_s;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_nx_s),
    .quo_o     (quo_nx_s)
  );

  assign busy_s = (state_q != IDLE);
  assign fire_s = busy_s && (cnt_q == '0) && !flush;

  // Sign-extend (or zero-extend) operands so a plain 64-bit product is correct.
  always_comb begin
    ext_a_s = {{XLEN{is_signed & op_a[XLEN-1]}}, op_a};
    ext_b_s = {{XLEN{is_signed & op_b[XLEN-1]}}, op_b};
  end

  // Completion value; the divide uses the final step's output with sign fixup.
  always_comb begin
    if (state_q == MUL_RUN) begin
      res_hi_s = prod_q[2*XLEN-1:XLEN];
      res_lo_s = prod_q[XLEN-1:0];
    end else if (dz_q) begin
      res_hi_s = a_q;
      res_lo_s = {XLEN{1'b1}};
    end else begin
      res_lo_s = qneg_q ? (~quo_nx_s + 32'd1) : quo_nx_s;
      res_hi_s = rneg_q ? (~rem_nx_s + 32'd1) : rem_nx_s;
    end
  end

  // Sequencer FSM, operand capture, iteration state and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= fire_s;
      case (state_q)
        IDLE: begin
          if (!flush && start_mult) begin
            state_q <= MUL_RUN;
            cnt_q   <= CNT_W'(MULT_CYCLES - 1);
            prod_q  <= ext_a_s * ext_b_s;
            dz_q    <= 1'b0;
            dbz_q   <= 1'b0;
          end else if (!flush && start_div) begin
            state_q <= DIV_RUN;
            cnt_q   <= CNT_W'(DIV_ITERS - 1);
            rem_q   <= '0;
            quo_q   <= abs32(op_a, is_signed);
            dvsr_q  <= abs32(op_b, is_signed);
            a_q     <= op_a;
            qneg_q  <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            rneg_q  <= is_signed & op_a[XLEN-1];
            dz_q    <= (op_b == '0);
            dbz_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (flush || (cnt_q == '0)) begin
            state_q <= IDLE;
            if (fire_s && (state_q == DIV_RUN) && dz_q) begin
              dbz_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 5'd1;
            if (state_q == DIV_RUN) begin
              rem_q <= rem_nx_s;
              quo_q <= quo_nx_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // A WB move-to wins its half over a same-edge completion.
      if (mthi_wb) begin
        hi_q <= wb_data;
      end else if (fire_s) begin
        hi_q <= res_hi_s;
      end
      if (mtlo_wb) begin
        lo_q <= wb_data;
      end else if (fire_s) begin
        lo_q <= res_lo_s;
      end
    end
  end

  assign busy        = busy_s;
  assign stall       = busy_s & (start_mult | start_div | mfhi_ex | mflo_ex);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed scenarios with hand-computed results and randomized traffic.
module tb_muldiv_ctrl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n, start_mult, start_div, is_signed;
  logic [31:0] op_a, op_b, wb_data;
  logic        mfhi_ex, mflo_ex, mthi_wb, mtlo_wb, flush;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  muldiv_ctrl #(.MULT_CYCLES(MC), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .mfhi_ex(mfhi_ex),
    .mflo_ex(mflo_ex), .mthi_wb(mthi_wb), .mtlo_wb(mtlo_wb), .wb_data(wb_data),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: operation in flight, edges left, pending result.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, r_hi = 32'd0, r_lo = 32'd0;
  bit          m_done = 1'b0, m_dbz = 1'b0, r_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; start_mult = 1'b0; start_div = 1'b0; is_signed = 1'b0;
    op_a = 32'd0; op_b = 32'd0; wb_data = 32'd0; mfhi_ex = 1'b0; mflo_ex = 1'b0;
    mthi_wb = 1'b0; mtlo_wb = 1'b0; flush = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit          wr;
    logic [63:0] pv;
    longint      sa, sb;
    int          ia, ib;
    wr = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dbz = 1'b0;
      return;
    end
    if (m_busy) begin
      if (flush) m_busy = 1'b0;
      else if (m_left == 1) begin wr = 1'b1; m_busy = 1'b0; end
      else m_left--;
    end else if (!flush && (start_mult || start_div)) begin
      m_busy = 1'b1;
      m_dbz  = 1'b0;
      if (start_mult) begin
        m_left = MC;
        r_dz   = 1'b0;
        if (is_signed) begin sa = $signed(op_a); sb = $signed(op_b); end
        else begin sa = {32'd0, op_a}; sb = {32'd0, op_b}; end
        pv   = sa * sb;
        r_hi = pv[63:32];
        r_lo = pv[31:0];
      end else begin
        m_left = 32;
        r_dz   = (op_b == 32'd0);
        if (r_dz) begin
          r_lo = 32'hFFFF_FFFF; r_hi = op_a;
        end else if (is_signed) begin
          if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
            r_lo = 32'h8000_0000; r_hi = 32'd0;
          end else begin
            ia = $signed(op_a); ib = $signed(op_b);
            r_lo = ia / ib; r_hi = ia % ib;
          end
        end else begin
          r_lo = op_a / op_b; r_hi = op_a % op_b;
        end
      end
    end
    if (wr && r_dz) m_dbz = 1'b1;
    m_hi   = mthi_wb ? wb_data : (wr ? r_hi : m_hi);
    m_lo   = mtlo_wb ? wb_data : (wr ? r_lo : m_lo);
    m_done = wr;
  endtask

  // One cycle: compare outputs mid-cycle, update model, take the edge.
  task automatic step();
    @(negedge clk);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("div_by_zero", div_by_zero, m_dbz);
    chk("stall", stall, m_busy & (start_mult | start_div | mfhi_ex | mflo_ex));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit div, input bit sg, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    start_mult = !div; start_div = div; is_signed = sg; op_a = a; op_b = b;
    step();
    idle_inputs();
  endtask

  task automatic idle_steps(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0:       pick_op = 32'd0;
      1:       pick_op = 32'hFFFF_FFFF;
      2:       pick_op = 32'h8000_0000;
      3:       pick_op = $urandom_range(0, 15);
      default: pick_op = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] sv_hi, sv_lo;
    bit          seen;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mfhi_ex = 1'b1;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_dbz", div_by_zero, 1'b0);

    // multu 0xFFFFFFFF * 2
    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    idle_steps(MC);
    chk("multu_done", done, 1'b1);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    idle_steps(1);
    chk("multu_done_once", done, 1'b0);

    // div -7 / 2
    start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    idle_steps(31);
    chk("div_not_yet", done, 1'b0);
    idle_steps(1);
    chk("div_done", done, 1'b1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // div 0x80000000 / -1
    start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_steps(32);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // divu 5 / 0
    start_op(1'b1, 1'b0, 32'd5, 32'd0);
    idle_steps(32);
    chk("dz_done", done, 1'b1);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", div_by_zero, 1'b1);

    // mflo hazard during divu 100 / 7
    start_op(1'b1, 1'b0, 32'd100, 32'd7);
    idle_steps(2);
    mflo_ex = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        chk("hazard_release", stall, 1'b0);
        chk("hazard_lo", lo, 32'd14);
        chk("hazard_hi", hi, 32'd2);
      end else begin
        chk("hazard_stall", stall, 1'b1);
      end
    end
    if (!seen) chk("hazard_timeout", 1'b0, 1'b1);

    // start_mult held while a divide is busy, accepted in the done cycle
    start_op(1'b1, 1'b0, 32'd9, 32'd3);
    start_mult = 1'b1; op_a = 32'd6; op_b = 32'd7;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        chk("b2b_stall_free", stall, 1'b0);
        chk("b2b_div_lo", lo, 32'd3);
      end
    end
    if (!seen) chk("b2b_timeout", 1'b0, 1'b1);
    step();
    chk("b2b_accepted", busy, 1'b1);
    idle_steps(MC);
    chk("b2b_mul_lo", lo, 32'd42);
    chk("b2b_mul_hi", hi, 32'd0);

    // flush at cycle 10 of a divide
    sv_hi = hi; sv_lo = lo;
    start_op(1'b1, 1'b1, 32'd1000, 32'd3);
    idle_steps(9);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_idle", busy, 1'b0);
    chk("flush_hi", hi, sv_hi);
    chk("flush_lo", lo, sv_lo);
    idle_steps(1);
    chk("flush_no_done", done, 1'b0);

    // reset mid-multiply
    start_op(1'b0, 1'b0, 32'd3, 32'd5);
    idle_steps(2);
    rst_n = 1'b0;
    step();
    idle_inputs();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);

    // mthi collides with multiply completion
    start_op(1'b0, 1'b0, 32'h0001_0000, 32'h0003_0003);
    idle_steps(MC - 1);
    mthi_wb = 1'b1; wb_data = 32'h1234;
    step();
    idle_inputs();
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h0003_0000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) start_mult = 1'b1;
        else start_div = 1'b1;
      end
      is_signed = $urandom_range(0, 1);
      op_a      = pick_op();
      op_b      = pick_op();
      mfhi_ex   = ($urandom_range(0, 3) == 0);
      mflo_ex   = ($urandom_range(0, 3) == 0);
      mthi_wb   = ($urandom_range(0, 9) == 0);
      mtlo_wb   = ($urandom_range(0, 9) == 0);
      wb_data   = $urandom;
      step();
    end
    idle_steps(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
